led_chaser_ctrl: RTL and testbench

//  Timed 3-bit position generator; pos drives the 3-to-8 one-hot decoder (pos -> ival) to light one of 8 LEDs.
//  A prescaler turns the system clock into a slow step rate; an IDLE/RUN FSM advances pos up or down.

---
 rtl/led_chaser_pkg.sv | 22 ++
 rtl/led_chaser_ctrl_tick_gen.sv | 43 ++++
 rtl/led_chaser_ctrl.sv | 118 +++++++++++
 tb/tb_led_chaser_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_chaser_pkg.sv
// Shared types and constants for the LED chaser position generator.
package led_chaser_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} chaser_state_t;

  localparam int unsigned POS_W   = 3;
  localparam int unsigned NUM_POS = 8;

  localparam logic [POS_W-1:0] POS_MIN = '0;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_POS - 1);

  // Next position modulo NUM_POS; down=1 decrements.
  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos, input logic down);
    return down ? (pos - POS_W'(1)) : (pos + POS_W'(1));
  endfunction

  // True when the next move in the given direction crosses the 7/0 boundary.
  function automatic logic pos_at_end(input logic [POS_W-1:0] pos, input logic down);
    return down ? (pos == POS_MIN) : (pos == POS_MAX);
  endfunction

endpackage

// File: rtl/led_chaser_ctrl_tick_gen.sv
// Prescaler for the LED chaser: counts 0..TICK_DIV-1 while enabled and
// pulses tick for the cycle spent at the terminal count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_LAST);
  // Tick is not masked by clr so a stop on the terminal count still advances.
  assign tick = en & w_tc;

  // Next count: held at zero when disabled or cleared, wraps at terminal count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!en || clr || w_tc) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/led_chaser_ctrl.sv
// LED chaser controller: IDLE/RUN FSM stepping a 3-bit position up or down,
// with single-step in IDLE and a one-cycle wrap pulse at endpoint events.
// Define LED_CHASER_BOUNCE_EN to add the bounce port (ping-pong sweep in RUN).
module led_chaser_ctrl
  import led_chaser_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
`ifdef LED_CHASER_BOUNCE_EN
  input  logic             bounce,
`endif
  output logic [POS_W-1:0] pos,
  output logic             running,
  output logic             wrap
);

  chaser_state_t    r_state;
  chaser_state_t    w_state_nxt;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             r_running;
  logic             w_tick;
  logic             w_bounce;
  logic             w_in_run;

`ifdef LED_CHASER_BOUNCE_EN
  assign w_bounce = bounce;
`else
  assign w_bounce = 1'b0;
`endif

  assign w_in_run = (r_state == ST_RUN);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_in_run),
    .clr   (stop),
    .tick  (w_tick)
  );

  // Next-state, position, latched direction and wrap pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (stop) begin
          // stop beats start; nothing else happens this cycle
          w_state_nxt = ST_IDLE;
        end else if (start) begin
          w_state_nxt = ST_RUN;
          w_dir_nxt   = dir;
        end else if (step) begin
          // Single-step always wraps, independent of bounce.
          w_pos_nxt  = pos_step(r_pos, dir);
          w_wrap_nxt = pos_at_end(r_pos, dir);
        end
      end
      ST_RUN: begin
        if (w_tick) begin
          if (pos_at_end(r_pos, r_dir)) begin
            w_wrap_nxt = 1'b1;
            if (w_bounce) begin
              // Turn around: move back inward and reverse the sweep.
              w_pos_nxt = pos_step(r_pos, ~r_dir);
              w_dir_nxt = ~r_dir;
            end else begin
              w_pos_nxt = pos_step(r_pos, r_dir);
            end
          end else begin
            w_pos_nxt = pos_step(r_pos, r_dir);
          end
        end
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pos     <= '0;
      r_dir     <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_wrap    <= w_wrap_nxt;
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  assign pos     = r_pos;
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// Directed bench for led_chaser_ctrl with TICK_DIV=4. Expected {pos,running,wrap}
// values are queued when stimulus is applied and compared when the DUT settles.
module tb_led_chaser_ctrl;

  localparam int unsigned TD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       step  = 1'b0;
  logic       dir   = 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
  logic       bounce = 1'b0;
`endif
  logic [2:0] pos;
  logic       running;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_chaser_ctrl #(
    .TICK_DIV (TD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .dir     (dir),
`ifdef LED_CHASER_BOUNCE_EN
    .bounce  (bounce),
`endif
    .pos     (pos),
    .running (running),
    .wrap    (wrap)
  );

  task automatic push(input string tag, input logic [2:0] p, input logic r, input logic w);
    exp_t e;
    e.tag = tag;
    e.val = {p, r, w};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [4:0] obs;
    obs = {pos, running, wrap};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed pos=%0d running=%b wrap=%b expected pos=%0d running=%b wrap=%b",
               e.tag, obs[4:2], obs[1], obs[0], e.val[4:2], e.val[1], e.val[0]);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the expectation now, let n cycles elapse, then compare.
  task automatic expect_after(input string tag, input logic [2:0] p, input logic r,
                              input logic w, input int n);
    push(tag, p, r, w);
    cyc(n);
    pop_check();
  endtask

  initial begin
    // Reset state
    expect_after("reset", 3'd0, 1'b0, 1'b0, 1);
    rst_n = 1'b1;
    cyc(1);

    // Run up from 0, first advance after TD cycles, wrap 7->0
    start = 1'b1; dir = 1'b0;
    expect_after("run_enter", 3'd0, 1'b1, 1'b0, 1);
    start = 1'b0;
    expect_after("first_adv_pending", 3'd0, 1'b1, 1'b0, 3);
    expect_after("first_adv", 3'd1, 1'b1, 1'b0, 1);
    for (int k = 2; k <= 7; k++) begin
      expect_after("run_up", 3'(k), 1'b1, 1'b0, TD);
    end
    expect_after("wrap_up", 3'd0, 1'b1, 1'b1, TD);
    expect_after("wrap_clear", 3'd0, 1'b1, 1'b0, 1);
    stop = 1'b1;
    expect_after("stop_up", 3'd0, 1'b0, 1'b0, 1);
    stop = 1'b0;

    // Run down from 0, dir changes mid-RUN are ignored
    start = 1'b1; dir = 1'b1;
    expect_after("run_enter_dn", 3'd0, 1'b1, 1'b0, 1);
    start = 1'b0;
    expect_after("wrap_dn", 3'd7, 1'b1, 1'b1, TD);
    dir = 1'b0;
    expect_after("dir_ignored", 3'd6, 1'b1, 1'b0, TD);
    stop = 1'b1;
    expect_after("stop_dn", 3'd6, 0, 0, 1);
    stop = 1'b0;

    // Single steps in IDLE: 6 -> 5 -> 4 -> 3, up to 4, down to 3
    dir = 1'b1; step = 1'b1;
    expect_after("step_dn5", 3'd5, 1'b0, 1'b0, 1);
    expect_after("step_dn4", 3'd4, 1'b0, 1'b0, 1);
    expect_after("step_dn3", 3'd3, 1'b0, 1'b0, 1);
    dir = 1'b0;
    expect_after("step_up4", 3'd4, 1'b0, 1'b0, 1);
    dir = 1'b1;
    expect_after("step_dn3b", 3'd3, 1'b0, 1'b0, 1);
    step = 1'b0;

    // Stop with a partial count, restart needs a full TD cycles
    start = 1'b1; dir = 1'b0;
    expect_after("run_p", 3'd3, 1'b1, 1'b0, 1);
    start = 1'b0;
    cyc(1);
    stop = 1'b1;
    expect_after("stop_partial", 3'd3, 1'b0, 1'b0, 1);
    stop = 1'b0;
    expect_after("idle_hold", 3'd3, 1'b0, 1'b0, 3);
    start = 1'b1;
    expect_after("restart", 3'd3, 1'b1, 1'b0, 1);
    start = 1'b0;
    expect_after("no_early_adv", 3'd3, 1'b1, 1'b0, 3);
    expect_after("full_count", 3'd4, 1'b1, 1'b0, 1);
    stop = 1'b1;
    expect_after("stop_r", 3'd4, 1'b0, 1'b0, 1);
    stop = 1'b0;

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    expect_after("start_stop", 3'd4, 1'b0, 1'b0, 1);
    start = 1'b0; stop = 1'b0;
    expect_after("still_idle", 3'd4, 1'b0, 1'b0, 2);

    // stop on the terminal-count cycle: advance then IDLE
    start = 1'b1;
    expect_after("run_tc", 3'd4, 1'b1, 1'b0, 1);
    start = 1'b0;
    cyc(3);
    stop = 1'b1;
    expect_after("stop_tc", 3'd5, 1'b0, 1'b0, 1);
    stop = 1'b0;

    // step ignored in RUN
    start = 1'b1; dir = 1'b0;
    expect_after("run_s", 3'd5, 1'b1, 1'b0, 1);
    start = 1'b0; step = 1'b1; dir = 1'b1;
    expect_after("step_ignored", 3'd5, 1'b1, 1'b0, 3);
    step = 1'b0;
    expect_after("adv_s", 3'd6, 1'b1, 1'b0, 1);
    stop = 1'b1;
    expect_after("stop_s", 3'd6, 1'b0, 1'b0, 1);
    stop = 1'b0;

    // Step wrap both ways
    dir = 1'b0; step = 1'b1;
    expect_after("step7", 3'd7, 1'b0, 1'b0, 1);
    expect_after("step_wrap_up", 3'd0, 1'b0, 1'b1, 1);
    dir = 1'b1;
    expect_after("step_wrap_dn", 3'd7, 1'b0, 1'b1, 1);
    step = 1'b0;
    expect_after("wrap_one_cycle", 3'd7, 1'b0, 1'b0, 1);

    // Asynchronous reset while running at pos 5
    dir = 1'b1; step = 1'b1;
    expect_after("step6", 3'd6, 1'b0, 1'b0, 1);
    expect_after("step5", 3'd5, 1'b0, 1'b0, 1);
    step = 1'b0;
    start = 1'b1; dir = 1'b0;
    expect_after("run_rst", 3'd5, 1'b1, 1'b0, 1);
    start = 1'b0;
    cyc(1);
    #2 rst_n = 1'b0;
    #1 push("reset_async", 3'd0, 1'b0, 1'b0);
    pop_check();
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

`ifdef LED_CHASER_BOUNCE_EN
    // Ping-pong from 5: 6, 7, 6 (wrap), 5
    dir = 1'b0; step = 1'b1;
    cyc(5);
    step = 1'b0;
    expect_after("bounce_pre", 3'd5, 1'b0, 1'b0, 1);
    bounce = 1'b1; start = 1'b1;
    expect_after("bounce_run", 3'd5, 1'b1, 1'b0, 1);
    start = 1'b0;
    expect_after("bounce6", 3'd6, 1'b1, 1'b0, TD);
    expect_after("bounce7", 3'd7, 1'b1, 1'b0, TD);
    expect_after("bounce_turn", 3'd6, 1'b1, 1'b1, TD);
    expect_after("bounce5", 3'd5, 1'b1, 1'b0, TD);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
